// File: rtl/dm_arb_pkg.sv
// -----------------------------------------------------------------------------
// dm_arb_pkg
// Shared definitions for the data-memory arbiter: FSM state encoding, DM
// geometry, and the port index constants used for grants and ownership.
// Configuration macro used by this slice: DM_ARB_RR_EN (see arb2).
// -----------------------------------------------------------------------------
package dm_arb_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    localparam int MEMORY_SIZE = 4096;
    localparam int MEMORY_BITS = 12;

    // Port indices; a grant or owner value is one of these.
    localparam logic CPU = 1'b0;
    localparam logic LDR = 1'b1;

endpackage : dm_arb_pkg

// File: rtl/dm_arbiter_arb2.sv
// -----------------------------------------------------------------------------
// arb2
// Combinational 2-way grant for the DM arbiter.
// Macro DM_ARB_RR_EN: defined   -> round-robin (contended grant goes to the
//                                  port that did not win last time)
//                     undefined -> fixed priority, port 0 (CPU) always wins
// Ports:
//   i_valid[1:0]    request valid per port
//   i_last_g        port granted on the most recent handshake
//   i_take          a handshake happens this cycle on the granted port
//   o_any           at least one request is valid
//   o_grant         selected port index (meaningful while o_any)
//   o_last_g_next   next value of the arbitration pointer
// -----------------------------------------------------------------------------
module arb2
    import dm_arb_pkg::*;
(
    input  logic [1:0] i_valid,
    input  logic       i_last_g,
    input  logic       i_take,
    output logic       o_any,
    output logic       o_grant,
    output logic       o_last_g_next
);

    // Grant selection and pointer advance.
    always_comb begin
        o_any   = |i_valid;
        o_grant = CPU;
`ifdef DM_ARB_RR_EN
        if (i_valid == 2'b11) begin
            o_grant = ~i_last_g;
        end else if (i_valid[0]) begin
            o_grant = CPU;
        end else begin
            o_grant = LDR;
        end
`else
        // Fixed priority: the pointer is still tracked but never consulted.
        if (i_valid[0]) begin
            o_grant = CPU;
        end else begin
            o_grant = LDR;
        end
`endif
        // The pointer only moves on an actual handshake.
        if (i_take) begin
            o_last_g_next = o_grant;
        end else begin
            o_last_g_next = i_last_g;
        end
    end

endmodule : arb2

// File: rtl/dm_arbiter.sv
// -----------------------------------------------------------------------------
// dm_arbiter
// Shares the single-port data memory (1-cycle registered read) between the
// CPU load/store unit (port 0) and the loader/debug port (port 1).
// Writes issue in the handshake cycle and stay in IDLE; reads issue in the
// handshake cycle, then spend one RD_WAIT cycle returning dm_q to the owner.
// Grant policy is chosen by macro DM_ARB_RR_EN inside arb2.
// Ports:
//   clock, reset              rising-edge clock, synchronous active-high reset
//   reqN_valid/ready/we/addr/wdata   request handshake, N = 0,1
//   rspN_valid/rdata          read response pulse to the owning port
//   dm_address/data/rden/wren DM control (address truncated to MEM_BITS)
//   dm_q                      DM registered read data
//   busy                      a read is in flight (RD_WAIT)
// -----------------------------------------------------------------------------
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MEM_BITS = MEMORY_BITS
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic [31:0]       dm_address,
    output logic [DATA_W-1:0] dm_data,
    output logic              dm_rden,
    output logic              dm_wren,
    input  logic [DATA_W-1:0] dm_q,
    output logic              busy
);

    state_t            r_state;
    state_t            w_state_next;
    logic              r_owner;
    logic              r_last_g;
    logic              w_last_g_next;
    logic              w_any;
    logic              w_grant;
    logic              w_take;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_unused_addr_hi;

    arb2 u_arb2 (
        .i_valid       ({req1_valid, req0_valid}),
        .i_last_g      (r_last_g),
        .i_take        (w_take),
        .o_any         (w_any),
        .o_grant       (w_grant),
        .o_last_g_next (w_last_g_next)
    );

    // Payload of the granted port.
    assign w_sel_we    = (w_grant == LDR) ? req1_we    : req0_we;
    assign w_sel_addr  = (w_grant == LDR) ? req1_addr  : req0_addr;
    assign w_sel_wdata = (w_grant == LDR) ? req1_wdata : req0_wdata;

    // Address bits above the DM index are intentionally dropped.
    assign w_unused_addr_hi = ^w_sel_addr[ADDR_W-1:MEM_BITS];

    // A handshake needs IDLE, a valid request and no reset in the same cycle.
    assign w_take = !reset && (r_state == IDLE) && w_any;

    // Next-state and output decode; reset forces every output to its idle value
    // in the same cycle so a concurrent request or a pending response is killed.
    always_comb begin
        w_state_next = r_state;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        rsp0_valid   = 1'b0;
        rsp1_valid   = 1'b0;
        rsp0_rdata   = {DATA_W{1'b0}};
        rsp1_rdata   = {DATA_W{1'b0}};
        dm_address   = 32'd0;
        dm_data      = {DATA_W{1'b0}};
        dm_rden      = 1'b0;
        dm_wren      = 1'b0;
        busy         = 1'b0;
        if (reset) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        req0_ready                 = (w_grant == CPU);
                        req1_ready                 = (w_grant == LDR);
                        dm_address[MEM_BITS-1:0]   = w_sel_addr[MEM_BITS-1:0];
                        dm_data                    = w_sel_wdata;
                        if (w_sel_we) begin
                            dm_wren = 1'b1;
                        end else begin
                            dm_rden      = 1'b1;
                            w_state_next = RD_WAIT;
                        end
                    end else begin
                        w_state_next = IDLE;
                    end
                end
                RD_WAIT: begin
                    busy         = 1'b1;
                    w_state_next = IDLE;
                    if (r_owner == LDR) begin
                        rsp1_valid = 1'b1;
                        rsp1_rdata = dm_q;
                    end else begin
                        rsp0_valid = 1'b1;
                        rsp0_rdata = dm_q;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    // State, read owner and arbitration pointer registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_owner  <= CPU;
            r_last_g <= LDR;
        end else begin
            r_state  <= w_state_next;
            r_last_g <= w_last_g_next;
            if (w_take && !w_sel_we) begin
                r_owner <= w_grant;
            end else begin
                r_owner <= r_owner;
            end
        end
    end

endmodule : dm_arbiter

// File: doc/dm_arbiter.md
# dm_arbiter

Arbiter and sequencer sharing the single-port data memory (DM, 4096 words, 1-cycle registered read) between two requesters: port 0 is the CPU load/store unit, port 1 is the loader/debug port. The block accepts one request per handshake, drives DM address/data/rden/wren, and returns read data to the owning port one cycle after issue. It sits between the core's memory stage and the DM instance.

## Interface
- ADDR_W, 32, requester address width
- DATA_W, 32, data width
- MEM_BITS, 12, DM index bits; upper address bits are dropped
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- reqN_valid  in  1  request valid, N = 0,1
- reqN_ready  out  1  request accepted this cycle when valid && ready
- reqN_we  in  1  1 = write, 0 = read
- reqN_addr  in  ADDR_W  word address
- reqN_wdata  in  DATA_W  write data
- rspN_valid  out  1  read data valid, one-cycle pulse
- rspN_rdata  out  DATA_W  read data, meaningful only while rspN_valid
- dm_address  out  32  {zeros, addr[MEM_BITS-1:0]} of the granted request
- dm_data  out  DATA_W  write data to DM
- dm_rden  out  1  DM read enable
- dm_wren  out  1  DM write enable
- dm_q  in  DATA_W  DM registered read data
- busy  out  1  read in flight (state RD_WAIT)

## Operation
- FSM states: IDLE, RD_WAIT.
- IDLE: arbiter picks grant g from the valid requests; reqg_ready = 1, the other ready = 0. No valid request: both ready 0, dm_rden = dm_wren = 0.
- Handshake, write: dm_wren = 1 and dm_address/dm_data driven combinationally in the same cycle. DM commits the write at the closing edge. State stays IDLE.
- Handshake, read: dm_rden = 1 in the same cycle. The block records owner = g and moves to RD_WAIT.
- RD_WAIT: both ready = 0 and dm_rden = dm_wren = 0. rsp[owner]_valid = 1 and rsp[owner]_rdata = dm_q. Next state is IDLE.
- Requesters hold valid and payload stable until ready. Dropping valid before ready is legal; nothing is issued.
- Address truncation: bits above MEM_BITS-1 are ignored. No error is raised.
- Arbitration pointer last_g updates only on a handshake.

## Timing
- Reset values: both ready = 0, both rsp_valid = 0, rdata = 0, dm_rden = dm_wren = 0, dm_address = 0, busy = 0, state IDLE, last_g = 1 (port 0 wins first).
- Write: latency 0; sustained 1 write per cycle.
- Read: request in cycle N, response in cycle N+1. Throughput is 1 read per 2 cycles.
- Reset asserted in RD_WAIT aborts the read: no rsp_valid is issued.
- Reset in the same cycle as a valid request: no handshake, and no DM enable is asserted.
- Both ports valid in IDLE: exactly one is granted, selected per Configuration. The loser waits with ready = 0.

## Configuration
- DM_ARB_RR_EN defined: round-robin. When both ports are valid, grant goes to the port != last_g. With a single valid port, that port is granted.
- DM_ARB_RR_EN undefined: fixed priority, port 0 (CPU) always wins. last_g is still maintained but not used for selection.

## Structure
- Shared package dm_arb_pkg: state encoding (IDLE = 1'b0, RD_WAIT = 1'b1), MEMORY_SIZE = 4096, MEMORY_BITS = 12, port index constants CPU = 0, LDR = 1.
- Sub-module arb2: combinational 2-way grant from valid[1:0] and last_g. It holds the DM_ARB_RR_EN switch.
- Top level holds the FSM, owner/last_g registers, and the DM mux.

## Test plan
- Write then read, port 0: write addr 5 / data 0xDEADBEEF, then read addr 5. Response cycle after the read handshake shows rsp0_valid = 1, rdata = 0xDEADBEEF; rsp1_valid stays 0.
- Address truncation: port 1 writes addr 0x1005 / data 7, port 0 reads addr 5. Expect rdata = 7 and dm_address = 5 both times.
- Contention, both ports hold valid writes for 4 cycles:
  - with DM_ARB_RR_EN: grants go 0,1,0,1;
  - without it: grants go 0,0,0,0 and port 1 is never granted.
- Read back-pressure: port 0 read, port 1 write both valid. Port 0 is granted, ready = 0 on both in the RD_WAIT cycle, then port 1 is granted. busy = 1 only in RD_WAIT.
- Reset mid-read: assert reset in the RD_WAIT cycle. No rsp_valid is issued; all outputs are at reset values the next cycle. The first post-reset contention grants port 0.
- Idle: no valid for 10 cycles keeps dm_rden = dm_wren = 0 and both ready = 0.
